// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch/decode pipeline definitions.
//   - fetch_state_t : fetch FSM states
//   - if_id_t       : IF/ID register contents; the decode stage uses it too
//   - align_pc()    : forces a PC target to a word boundary
package pc_fetch_unit_pkg;

    localparam int          INSTR_W        = 32;
    localparam logic [31:0] RESET_ADDR_DEF = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP_DEF  = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
        logic               valid;
    } if_id_t;

    function automatic logic [31:0] align_pc(input logic [31:0] target);
        return {target[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if_id_reg.sv
// IF/ID pipeline register. Update priority is flush > stall > emit > bubble.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   flush      : squash the entry (valid=0, instr=NOP)
//   stall      : hold every field
//   emit       : load entry
//   entry      : new IF/ID contents when emit
//   q          : registered IF/ID contents
module if_id_reg
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [INSTR_W-1:0] INSTR_NOP = INSTR_NOP_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  logic   stall,
    input  logic   emit,
    input  if_id_t entry,
    output if_id_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '{pc: 32'd0, instr: INSTR_NOP, valid: 1'b0};
        end else if (flush) begin
            q.valid <= 1'b0;
            q.instr <= INSTR_NOP;
        end else if (stall) begin
            q <= q;
        end else if (emit) begin
            q <= entry;
        end else begin
            // bubble: pc field keeps the last emitted PC
            q.valid <= 1'b0;
            q.instr <= INSTR_NOP;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: holds the PC, issues req/ready instruction-memory requests,
// and fills the IF/ID register, handling stall, flush and redirect while a
// request is outstanding.
// Ports:
//   clk, rst_n         : clock, async active-low reset
//   next_addr_in       : next PC from the address mux (redirect target on flush)
//   flush_in, stall_in : branch/jump taken; IF/ID hold from the hazard unit
//   imem_*             : instruction memory request/response
//   seq_addr_out       : pc_q+4 to the mux's sequential input
//   pc_out, instr_out, valid_out : IF/ID register
//   misalign_out       : one-cycle pulse when a loaded target had bits[1:0]!=0
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEF,
    parameter logic [31:0] INSTR_NOP  = INSTR_NOP_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] next_addr_in,
    input  logic        flush_in,
    input  logic        stall_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic [31:0] imem_rdata_in,
    input  logic        imem_ready_in,
    output logic [31:0] seq_addr_out,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        valid_out,
    output logic        misalign_out
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  redir_q, redir_d;
    logic [31:0]  hold_q, hold_d;
    logic         req_en_q;      // keeps req low until the first clk after reset
    logic         misalign_q;
    logic         done;
    logic         load;
    logic [31:0]  load_tgt;
    logic         emit;
    if_id_t       emit_entry;
    if_id_t       if_id_q;

    assign imem_req_out  = req_en_q & (state_q != HOLD);
    assign imem_addr_out = pc_q;
    assign seq_addr_out  = pc_q + 32'd4;
    assign done          = imem_req_out & imem_ready_in;
    assign misalign_out  = misalign_q;

    always_comb begin
        state_d    = state_q;
        redir_d    = redir_q;
        hold_d     = hold_q;
        load       = 1'b0;
        load_tgt   = pc_q;
        emit       = 1'b0;
        emit_entry = '{pc: pc_q, instr: imem_rdata_in, valid: 1'b1};
        case (state_q)
            FETCH: begin
                if (flush_in) begin
                    if (done) begin
                        // fetched word is on the wrong path: drop it
                        load     = 1'b1;
                        load_tgt = next_addr_in;
                    end else begin
                        redir_d = next_addr_in;
                        state_d = DRAIN;
                    end
                end else if (done) begin
                    if (stall_in) begin
                        hold_d  = imem_rdata_in;
                        state_d = HOLD;
                    end else begin
                        emit     = 1'b1;
                        load     = 1'b1;
                        load_tgt = next_addr_in;
                    end
                end
            end
            DRAIN: begin
                // request at the old pc_q must complete before redirecting
                if (flush_in) begin
                    if (done) begin
                        load     = 1'b1;
                        load_tgt = next_addr_in;
                        state_d  = FETCH;
                    end else begin
                        redir_d = next_addr_in;
                    end
                end else if (done) begin
                    load     = 1'b1;
                    load_tgt = redir_q;
                    state_d  = FETCH;
                end
            end
            HOLD: begin
                if (flush_in) begin
                    load     = 1'b1;
                    load_tgt = next_addr_in;
                    state_d  = FETCH;
                end else if (!stall_in) begin
                    emit             = 1'b1;
                    emit_entry.instr = hold_q;
                    load             = 1'b1;
                    load_tgt         = next_addr_in;
                    state_d          = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
        pc_d = load ? align_pc(load_tgt) : pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            pc_q       <= RESET_ADDR;
            redir_q    <= 32'd0;
            hold_q     <= 32'd0;
            req_en_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redir_q    <= redir_d;
            hold_q     <= hold_d;
            req_en_q   <= 1'b1;
            misalign_q <= load & (|load_tgt[1:0]);
        end
    end

    if_id_reg #(.INSTR_NOP(INSTR_NOP)) u_if_id (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush_in),
        .stall (stall_in),
        .emit  (emit),
        .entry (emit_entry),
        .q     (if_id_q)
    );

    assign pc_out    = if_id_q.pc;
    assign instr_out = if_id_q.instr;
    assign valid_out = if_id_q.valid;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] next_addr_in = '0;
    logic        flush_in = 1'b0;
    logic        stall_in = 1'b0;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic [31:0] imem_rdata_in;
    logic        imem_ready_in = 1'b0;
    logic [31:0] seq_addr_out;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        valid_out;
    logic        misalign_out;

    pc_fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .next_addr_in  (next_addr_in),
        .flush_in      (flush_in),
        .stall_in      (stall_in),
        .imem_req_out  (imem_req_out),
        .imem_addr_out (imem_addr_out),
        .imem_rdata_in (imem_rdata_in),
        .imem_ready_in (imem_ready_in),
        .seq_addr_out  (seq_addr_out),
        .pc_out        (pc_out),
        .instr_out     (instr_out),
        .valid_out     (valid_out),
        .misalign_out  (misalign_out)
    );

    always #5 clk = ~clk;

    // memory contents: a distinct word per address
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_2468;
    endfunction

    assign imem_rdata_in = memf(imem_addr_out);

    typedef struct {
        logic [31:0] addr;
        logic [31:0] seq;
        logic        req;
        logic        mis;
        logic        v;
        logic [31:0] pco;
        logic [31:0] ins;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } emit_t;

    exp_t  cq[$];
    emit_t eq[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: fetch stage described as "current PC, maybe a pending
    // redirect, maybe a parked word" plus the visible IF/ID entry
    logic [31:0] m_pc, m_rt, m_hw, m_pco, m_ins;
    bit          m_started, m_rv, m_hv, m_v;

    task automatic model_reset();
        m_pc = 32'h0; m_started = 0; m_rv = 0; m_hv = 0;
        m_v = 0; m_pco = 32'h0; m_ins = NOP;
    endtask

    task automatic model_step(input bit f, input bit s, input bit r, input logic [31:0] na);
        bit req, done, ld, em, mis;
        logic [31:0] tgt, ew;
        exp_t e;
        emit_t it;
        req = m_started && !m_hv;
        done = req && r;
        ld = 0; em = 0; tgt = 32'h0; ew = 32'h0;
        if (f) begin
            if (done || m_hv) begin ld = 1; tgt = na; m_rv = 0; end
            else begin m_rv = 1; m_rt = na; end
            m_hv = 0;
        end else if (m_rv) begin
            if (done) begin ld = 1; tgt = m_rt; m_rv = 0; end
        end else if (m_hv) begin
            if (!s) begin em = 1; ew = m_hw; ld = 1; tgt = na; m_hv = 0; end
        end else if (done) begin
            if (s) begin m_hv = 1; m_hw = memf(m_pc); end
            else begin em = 1; ew = memf(m_pc); ld = 1; tgt = na; end
        end
        if (f) begin m_v = 0; m_ins = NOP; end
        else if (s) begin end
        else if (em) begin
            m_v = 1; m_pco = m_pc; m_ins = ew;
            it.pc = m_pc; it.ins = ew;
            eq.push_back(it);
        end else begin m_v = 0; m_ins = NOP; end
        mis = ld && (tgt[1:0] != 2'b00);
        if (ld) m_pc = tgt & 32'hFFFF_FFFC;
        m_started = 1;
        e.addr = m_pc; e.seq = m_pc + 32'd4; e.req = m_started && !m_hv;
        e.mis = mis; e.v = m_v; e.pco = m_pco; e.ins = m_ins;
        cq.push_back(e);
    endtask

    // called at a negedge; drives one cycle and returns at the next negedge
    task automatic cycle(input bit f, input bit s, input bit r, input bit seq, input logic [31:0] na);
        logic [31:0] a;
        a = seq ? (m_pc + 32'd4) : na;
        flush_in = f; stall_in = s; imem_ready_in = r; next_addr_in = a;
        model_step(f, s, r, a);
        @(negedge clk);
    endtask

    task automatic goto(input logic [31:0] target);
        for (int i = 0; i < 64 && m_pc != target; i++) cycle(0, 0, 1, 1, 0);
        chk("goto_pc", m_pc, target);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_req", {31'd0, imem_req_out}, 32'd0);
        chk("rst_addr", imem_addr_out, 32'h0);
        chk("rst_seq", seq_addr_out, 32'h4);
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_instr", instr_out, NOP);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_misalign", {31'd0, misalign_out}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // monitor: per-cycle outputs from cq, new IF/ID entries from eq
    initial begin
        exp_t  e;
        emit_t it;
        bit    s_st;
        forever begin
            @(posedge clk);
            s_st = stall_in;
            if (cq.size() > 0) begin
                e = cq.pop_front();
                #1;
                chk("imem_addr", imem_addr_out, e.addr);
                chk("seq_addr", seq_addr_out, e.seq);
                chk("imem_req", {31'd0, imem_req_out}, {31'd0, e.req});
                chk("misalign", {31'd0, misalign_out}, {31'd0, e.mis});
                chk("valid", {31'd0, valid_out}, {31'd0, e.v});
                chk("instr_out", instr_out, e.ins);
                chk("pc_out", pc_out, e.pco);
                if (valid_out && !s_st) begin
                    if (eq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL emit_unexpected actual pc=%h expected none", pc_out);
                    end else begin
                        it = eq.pop_front();
                        chk("emit_pc", pc_out, it.pc);
                        chk("emit_instr", instr_out, it.ins);
                    end
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        do_reset();
        // sequential, zero-wait
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1, 0);
        // ready low 3 cycles at 0x10
        goto(32'h10);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 1, 1, 0);
        // stall on the 0x20 response
        goto(32'h20);
        cycle(0, 1, 1, 1, 0);
        cycle(0, 1, 1, 1, 0);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 1, 0);
        // flush while 0x40 is pending
        goto(32'h40);
        cycle(1, 0, 0, 0, 32'h100);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 1, 0);
        // flush+stall in HOLD
        cycle(0, 1, 1, 1, 0);
        cycle(1, 1, 0, 0, 32'h200);
        cycle(0, 0, 1, 1, 0);
        // misaligned target, then wrap
        cycle(1, 0, 1, 0, 32'h203);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(1, 0, 1, 0, 32'hFFFF_FFFC);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 1, 0);
        // flush in DRAIN with a misaligned redirect, latest wins
        cycle(1, 0, 0, 0, 32'h300);
        cycle(1, 0, 0, 0, 32'h401);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 1, 0);
        // random traffic
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] na;
            na = $urandom;
            if ($urandom_range(1, 0) == 1) na[1:0] = 2'b00;
            cycle($urandom_range(7, 0) == 0, $urandom_range(4, 0) == 0,
                  $urandom_range(2, 0) != 0, $urandom_range(3, 0) != 0, na);
        end
        // reset with a request pending
        cycle(0, 0, 0, 1, 0);
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(7, 0) == 0, $urandom_range(4, 0) == 0,
                  $urandom_range(2, 0) != 0, $urandom_range(3, 0) != 0, $urandom & 32'hFFFF_FFFC);
        end
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1, 0);
        @(posedge clk);
        #2;
        chk("cq_drained", cq.size(), 32'd0);
        chk("eq_drained", eq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
